gvp_program_sequencer: RTL and testbench

GVP_PROGRAM_SEQUENCER -- requirements
Module: gvp_program_sequencer

---
 rtl/gvp_pkg.sv | 28 ++
 rtl/gvp_vec_assembler.sv | 46 ++++
 rtl/gvp_program_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_gvp_program_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gvp_pkg.sv
// Shared definitions for the GVP program sequencer: FSM encodings and the
// layout of the vector block that is handed to the vector core.
package gvp_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StCollect = 3'd1,
    StProgram = 3'd2,
    StGap     = 3'd3,
    StArmed   = 3'd4,
    StRun     = 3'd5,
    StDone    = 3'd6
  } gvp_state_e;

  localparam int unsigned WORD_W        = 32;
  localparam int unsigned WORDS_PER_VEC = 16;
  localparam int unsigned WORD_CNT_W    = 4;
  localparam int unsigned VEC_W         = WORD_W * WORDS_PER_VEC;

  // Vector core field layout: word 0 carries the target vector address.
  localparam int unsigned VP_WORD_ADDR  = 0;
  localparam int unsigned VP_ADDR_LSB   = 0;

  function automatic int unsigned word_lsb(input int unsigned k);
    return k * WORD_W;
  endfunction

endpackage

// File: rtl/gvp_vec_assembler.sv
// Collects 32-bit stream words into one 512-bit vector block and checks that
// tlast lands exactly on the final word.
module gvp_vec_assembler
  import gvp_pkg::*;
(
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  word_valid,
  input  logic [WORD_W-1:0]     word_data,
  input  logic                  word_last,
  output logic [VEC_W-1:0]      vec,
  output logic [WORD_CNT_W-1:0] word_cnt,
  output logic                  vec_done,
  output logic                  frame_err
);

  logic [VEC_W-1:0]      vec_q;
  logic [WORD_CNT_W-1:0] cnt_q;
  logic                  at_last;

  assign at_last   = (cnt_q == WORD_CNT_W'(WORDS_PER_VEC - 1));
  assign frame_err = word_valid && !flush && (word_last != at_last);
  assign vec_done  = word_valid && !flush && word_last && at_last;
  assign vec       = vec_q;
  assign word_cnt  = cnt_q;

  always_ff @(posedge clk) begin
    if (!resetn || flush) begin
      vec_q <= '0;
      cnt_q <= '0;
    end else if (word_valid) begin
      if (frame_err) begin
        // Misframed vector: drop everything collected so far.
        vec_q <= '0;
        cnt_q <= '0;
      end else begin
        for (int unsigned k = 0; k < WORDS_PER_VEC; k++) begin
          if (cnt_q == WORD_CNT_W'(k)) vec_q[word_lsb(k) +: WORD_W] <= word_data;
        end
        cnt_q <= at_last ? '0 : cnt_q + WORD_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gvp_program_sequencer.sv
// Loads vector blocks from an AXI-stream into the GVP core, then arms, runs
// and aborts the core on command.
module gvp_program_sequencer
  import gvp_pkg::*;
#(
  parameter int unsigned NUM_VECTORS_N2 = 4,
  parameter int unsigned NUM_VECTORS    = 16,
  parameter int unsigned SETVEC_HOLD    = 8
) (
  input  logic                      a_clk,
  input  logic                      a_resetn,
  input  logic [31:0]               s_axis_tdata,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic                      s_axis_tlast,
  input  logic                      cmd_start,
  input  logic                      cmd_abort,
  input  logic                      cmd_clear,
  input  logic                      gvp_finished,
  output logic                      gvp_reset,
  output logic                      setvec,
  output logic [511:0]              vp_set,
  output logic [NUM_VECTORS_N2:0]   vectors_loaded,
  output logic [2:0]                state,
  output logic                      done_pulse,
  output logic                      abort_pulse,
  output logic                      error
);

  localparam int unsigned LW    = NUM_VECTORS_N2 + 1;
  localparam int unsigned TMR_W = $clog2(SETVEC_HOLD + 1);

  gvp_state_e        state_q, state_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [LW-1:0]     loaded_q, loaded_d;
  logic              error_q, error_d;
  logic              clear_pend_q, clear_pend_d;
  logic              entry_armed_q, entry_armed_d;
  logic              done_q, done_d;
  logic              abort_q, abort_d;
  logic              tready_q, tready_d;
  logic              fin_q;

  logic                  accept;
  logic                  flush;
  logic                  vec_done;
  logic                  frame_err;
  logic                  tmr_last;
  logic                  fin_rise;
  logic [WORD_CNT_W-1:0] word_cnt;

  assign accept   = s_axis_tvalid && tready_q;
  assign tmr_last = (tmr_q == TMR_W'(SETVEC_HOLD - 1));
  assign fin_rise = gvp_finished && !fin_q;

  gvp_vec_assembler u_asm (
    .clk        (a_clk),
    .resetn     (a_resetn),
    .flush      (flush),
    .word_valid (accept),
    .word_data  (s_axis_tdata),
    .word_last  (s_axis_tlast),
    .vec        (vp_set),
    .word_cnt   (word_cnt),
    .vec_done   (vec_done),
    .frame_err  (frame_err)
  );

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    loaded_d      = loaded_q;
    error_d       = error_q;
    clear_pend_d  = clear_pend_q;
    entry_armed_d = entry_armed_q;
    done_d        = 1'b0;
    abort_d       = 1'b0;
    flush         = 1'b0;

    if (cmd_clear && (state_q != StProgram) && (state_q != StGap)) begin
      state_d  = StIdle;
      loaded_d = '0;
      error_d  = 1'b0;
      flush    = 1'b1;
    end else begin
      case (state_q)
        StIdle, StArmed: begin
          if (accept) begin
            if (frame_err) begin
              error_d = 1'b1;
            end else begin
              state_d       = StCollect;
              entry_armed_d = (state_q == StArmed);
            end
          end else if ((state_q == StArmed) && cmd_start && !cmd_abort) begin
            state_d = StRun;
          end
        end
        StCollect: begin
          if (frame_err) begin
            error_d = 1'b1;
            state_d = entry_armed_q ? StArmed : StIdle;
          end else if (vec_done) begin
            state_d = StProgram;
            tmr_d   = '0;
            // Table already full: still program it, but flag the overflow.
            if (loaded_q == LW'(NUM_VECTORS)) error_d = 1'b1;
          end
        end
        StProgram: begin
          if (cmd_clear) clear_pend_d = 1'b1;
          if (tmr_last) begin
            tmr_d   = '0;
            state_d = StGap;
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        StGap: begin
          if (cmd_clear) clear_pend_d = 1'b1;
          if (tmr_last) begin
            tmr_d = '0;
            if (clear_pend_q || cmd_clear) begin
              state_d      = StIdle;
              loaded_d     = '0;
              error_d      = 1'b0;
              clear_pend_d = 1'b0;
              flush        = 1'b1;
            end else begin
              state_d = StArmed;
              if (loaded_q != LW'(NUM_VECTORS)) loaded_d = loaded_q + LW'(1);
            end
          end else begin
            tmr_d = tmr_q + TMR_W'(1);
          end
        end
        StRun: begin
          if (cmd_abort) begin
            state_d = StArmed;
            abort_d = 1'b1;
          end else if (fin_rise) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
        StDone:  state_d = StArmed;
        default: state_d = StIdle;
      endcase
    end

    tready_d = (state_d == StIdle) || (state_d == StCollect) || (state_d == StArmed);
  end

  always_ff @(posedge a_clk) begin
    if (!a_resetn) begin
      state_q       <= StIdle;
      tmr_q         <= '0;
      loaded_q      <= '0;
      error_q       <= 1'b0;
      clear_pend_q  <= 1'b0;
      entry_armed_q <= 1'b0;
      done_q        <= 1'b0;
      abort_q       <= 1'b0;
      tready_q      <= 1'b0;
      fin_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      loaded_q      <= loaded_d;
      error_q       <= error_d;
      clear_pend_q  <= clear_pend_d;
      entry_armed_q <= entry_armed_d;
      done_q        <= done_d;
      abort_q       <= abort_d;
      tready_q      <= tready_d;
      fin_q         <= gvp_finished;
    end
  end

  assign s_axis_tready  = tready_q;
  assign gvp_reset      = (state_q != StRun);
  assign setvec         = (state_q == StProgram);
  assign vectors_loaded = loaded_q;
  assign state          = state_q;
  assign done_pulse     = done_q;
  assign abort_pulse    = abort_q;
  assign error          = error_q;

endmodule

// File: tb/tb_gvp_program_sequencer.sv
// Directed bench for gvp_program_sequencer: a vector-load table followed by
// hand-written run/abort/clear/reset sequences.
module tb_gvp_program_sequencer;

  logic         a_clk = 1'b0;
  logic         a_resetn;
  logic [31:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic         cmd_start, cmd_abort, cmd_clear;
  logic         gvp_finished;
  logic         gvp_reset;
  logic         setvec;
  logic [511:0] vp_set;
  logic [4:0]   vectors_loaded;
  logic [2:0]   state;
  logic         done_pulse, abort_pulse, error;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 a_clk = ~a_clk;

  gvp_program_sequencer dut (
    .a_clk          (a_clk),
    .a_resetn       (a_resetn),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .cmd_start      (cmd_start),
    .cmd_abort      (cmd_abort),
    .cmd_clear      (cmd_clear),
    .gvp_finished   (gvp_finished),
    .gvp_reset      (gvp_reset),
    .setvec         (setvec),
    .vp_set         (vp_set),
    .vectors_loaded (vectors_loaded),
    .state          (state),
    .done_pulse     (done_pulse),
    .abort_pulse    (abort_pulse),
    .error          (error)
  );

  typedef struct {
    logic [31:0] addr;
    int          last_at;     // word index carrying tlast; 16 = never
    int          exp_setvec;
    int          exp_loaded;
    int          exp_err;
    int          exp_state;
  } vec_t;

  vec_t tbl[4];

  task automatic tick();
    @(posedge a_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic stream_vec(input logic [31:0] addr, input int last_at);
    int w;
    for (int k = 0; k < 16; k++) begin
      w = 0;
      while (!s_axis_tready && w < 100) begin
        tick();
        w++;
      end
      if (w >= 100) check("tready_timeout", 32'(s_axis_tready), 32'd1);
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = (k == 0) ? addr : 32'(k);
      s_axis_tlast  = (k == last_at);
      tick();
      if (k == last_at) break;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic settle();
    repeat (20) tick();
  endtask

  initial begin
    int          n_sv;
    int          n_done;
    logic        changed;
    logic [511:0] cap;

    tbl[0] = '{32'd3, 15, 8, 1, 0, 4};
    tbl[1] = '{32'd5,  9, 0, 1, 1, 4};
    tbl[2] = '{32'd6, 15, 8, 2, 1, 4};
    tbl[3] = '{32'd7, 16, 0, 2, 1, 4};

    a_resetn = 1'b0;
    s_axis_tdata = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    cmd_start = 1'b0; cmd_abort = 1'b0; cmd_clear = 1'b0; gvp_finished = 1'b0;
    tick(); tick();
    check("rst_state",  32'(state), 32'd0);
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    check("rst_gvp_reset", 32'(gvp_reset), 32'd1);
    check("rst_setvec", 32'(setvec), 32'd0);
    check("rst_loaded", 32'(vectors_loaded), 32'd0);
    check("rst_error",  32'(error), 32'd0);
    a_resetn = 1'b1;
    tick();
    check("idle_tready", 32'(s_axis_tready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      stream_vec(tbl[i].addr, tbl[i].last_at);
      n_sv = 0;
      changed = 1'b0;
      cap = '0;
      for (int c = 0; c < 20; c++) begin
        if (setvec) begin
          if (n_sv == 0) cap = vp_set;
          else if (vp_set !== cap) changed = 1'b1;
          n_sv++;
        end
        tick();
      end
      check($sformatf("v%0d_setvec_cycles", i), 32'(n_sv), 32'(tbl[i].exp_setvec));
      check($sformatf("v%0d_loaded", i), 32'(vectors_loaded), 32'(tbl[i].exp_loaded));
      check($sformatf("v%0d_error", i), 32'(error), 32'(tbl[i].exp_err));
      check($sformatf("v%0d_state", i), 32'(state), 32'(tbl[i].exp_state));
      if (tbl[i].exp_setvec > 0) begin
        check($sformatf("v%0d_w0", i), cap[31:0], tbl[i].addr);
        check($sformatf("v%0d_w1", i), cap[63:32], 32'd1);
        check($sformatf("v%0d_w2", i), cap[95:64], 32'd2);
        check($sformatf("v%0d_w15", i), cap[511:480], 32'd15);
        check($sformatf("v%0d_vp_held", i), 32'(changed), 32'd0);
      end
    end

    // Immediate clear from ARMED.
    cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    check("clr_state", 32'(state), 32'd0);
    check("clr_loaded", 32'(vectors_loaded), 32'd0);
    check("clr_error", 32'(error), 32'd0);

    // cmd_start outside ARMED is ignored.
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("idle_start_state", 32'(state), 32'd0);
    check("idle_start_gvp_reset", 32'(gvp_reset), 32'd1);

    stream_vec(32'd1, 15);
    settle();
    check("arm_state", 32'(state), 32'd4);

    // Start, then finished edge -> single done pulse.
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("run_state", 32'(state), 32'd5);
    check("run_gvp_reset", 32'(gvp_reset), 32'd0);
    tick(); tick();
    check("run_hold_state", 32'(state), 32'd5);
    gvp_finished = 1'b1;
    tick();
    check("done_state", 32'(state), 32'd6);
    check("done_pulse_hi", 32'(done_pulse), 32'd1);
    check("done_gvp_reset", 32'(gvp_reset), 32'd1);
    n_done = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (done_pulse) n_done++;
    end
    check("done_extra_pulses", 32'(n_done), 32'd0);
    check("done_back_armed", 32'(state), 32'd4);
    gvp_finished = 1'b0;
    tick();

    // Abort and finished edge together: abort wins.
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("rerun_state", 32'(state), 32'd5);
    cmd_abort = 1'b1; gvp_finished = 1'b1;
    tick();
    cmd_abort = 1'b0;
    check("abort_state", 32'(state), 32'd4);
    check("abort_pulse_hi", 32'(abort_pulse), 32'd1);
    check("abort_no_done", 32'(done_pulse), 32'd0);
    check("abort_gvp_reset", 32'(gvp_reset), 32'd1);
    tick();
    check("abort_pulse_lo", 32'(abort_pulse), 32'd0);
    check("abort_done_lo", 32'(done_pulse), 32'd0);
    gvp_finished = 1'b0;
    tick();

    // Start and abort together in ARMED: stay ARMED.
    cmd_start = 1'b1; cmd_abort = 1'b1;
    tick();
    cmd_start = 1'b0; cmd_abort = 1'b0;
    check("start_abort_state", 32'(state), 32'd4);
    check("start_abort_gvp_reset", 32'(gvp_reset), 32'd1);
    check("start_abort_no_pulse", 32'(abort_pulse), 32'd0);

    // Reset mid-RUN.
    cmd_start = 1'b1; tick(); cmd_start = 1'b0;
    check("prerst_state", 32'(state), 32'd5);
    a_resetn = 1'b0;
    tick();
    check("midrst_state", 32'(state), 32'd0);
    check("midrst_gvp_reset", 32'(gvp_reset), 32'd1);
    check("midrst_setvec", 32'(setvec), 32'd0);
    check("midrst_vp_zero", 32'(vp_set == '0), 32'd1);
    check("midrst_loaded", 32'(vectors_loaded), 32'd0);
    check("midrst_error", 32'(error), 32'd0);
    check("midrst_done", 32'(done_pulse), 32'd0);
    check("midrst_abort", 32'(abort_pulse), 32'd0);
    check("midrst_tready", 32'(s_axis_tready), 32'd0);
    a_resetn = 1'b1;
    tick();
    check("postrst_tready", 32'(s_axis_tready), 32'd1);

    // Fill the table, overflow with a 17th, clear during GAP.
    for (int v = 0; v < 16; v++) begin
      stream_vec(32'(v), 15);
      settle();
    end
    check("full_loaded", 32'(vectors_loaded), 32'd16);
    check("full_error", 32'(error), 32'd0);
    check("full_state", 32'(state), 32'd4);
    stream_vec(32'd16, 15);
    check("ovf_setvec", 32'(setvec), 32'd1);
    check("ovf_state", 32'(state), 32'd2);
    check("ovf_error", 32'(error), 32'd1);
    check("ovf_loaded", 32'(vectors_loaded), 32'd16);
    repeat (10) tick();
    check("gap_state", 32'(state), 32'd3);
    cmd_clear = 1'b1; tick(); cmd_clear = 1'b0;
    check("gap_clr_deferred", 32'(state), 32'd3);
    check("gap_clr_err_kept", 32'(error), 32'd1);
    repeat (6) tick();
    check("gap_clr_state", 32'(state), 32'd0);
    check("gap_clr_loaded", 32'(vectors_loaded), 32'd0);
    check("gap_clr_error", 32'(error), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
